// File: rtl/multi_sonic_ranger.sv
// -----------------------------------------------------------------------------
// multi_sonic_ranger
//
// Round-robin driver for N_CH ultrasonic range sensors (HC-SR04 style).
// Each slot fires a trigger pulse on the selected channel. It then waits for
// the echo to rise and times how long the echo stays high, in microseconds.
// The result lands in that channel's dis field, together with a one-cycle
// dis_valid strobe. If the echo never rises, or stays high too long, the
// channel reports all ones and sets its timeout flag. Every slot lasts
// PERIOD_US microseconds from trigger start. After that the next channel is
// selected.
//
// Ports
//   clk_50m   : system clock, rising edge
//   rst       : synchronous reset, active low
//   en        : enables round-robin ranging
//   echo      : asynchronous echo inputs, one per channel
//   trig      : trigger outputs, at most one bit high
//   dis       : per-channel echo time in us, channel k at [k*DIS_W +: DIS_W]
//   dis_valid : one-cycle strobe when a channel's dis/timeout is updated
//   timeout   : per-channel flag, last measurement timed out
//   ch_sel    : index of the channel currently being serviced
//   busy      : high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module multi_sonic_ranger #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int N_CH       = 4,
  parameter int DIS_W      = 16,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 30000,
  parameter int PERIOD_US  = 60000,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk_50m,
  input  logic                  rst,
  input  logic                  en,
  input  logic [N_CH-1:0]       echo,
  output logic [N_CH-1:0]       trig,
  output logic [N_CH*DIS_W-1:0] dis,
  output logic [N_CH-1:0]       dis_valid,
  output logic [N_CH-1:0]       timeout,
  output logic [CH_W-1:0]       ch_sel,
  output logic                  busy
);

  localparam int DIV       = CLK_HZ / 1_000_000;
  localparam int PRE_W     = $clog2(DIV);
  localparam int TRIG_BITS = $clog2(TRIG_US + 1);
  // The phase counter times the trigger, the rise wait and the echo. It must
  // be wide enough for both the trigger length and the result width.
  localparam int PH_W      = (DIS_W > TRIG_BITS) ? DIS_W : TRIG_BITS;
  localparam int SLOT_W    = $clog2(PERIOD_US + 1);

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(DIV - 1);
  localparam logic [PH_W-1:0]   TRIG_END  = PH_W'(TRIG_US);
  localparam logic [PH_W-1:0]   TO_LAST   = PH_W'(TIMEOUT_US - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(PERIOD_US - 1);
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(N_CH - 1);

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    GAP
  } state_t;

  state_t              state_reg, state_next;
  logic [PRE_W-1:0]    pre_reg;
  logic                tick;
  logic [PH_W-1:0]     cnt_reg, cnt_next;
  logic [SLOT_W-1:0]   slot_reg, slot_next;
  logic [CH_W-1:0]     ch_sel_reg, ch_sel_next;
  logic [N_CH-1:0]     echo_sync;
  logic [N_CH-1:0]     echo_prev;
  logic                sel_now, sel_prev;
  logic                echo_rise, echo_fall;
  logic                res_load, res_to;
  logic [DIS_W-1:0]    res_val;

  // ---------------------------------------------------------------------------
  // Free-running microsecond prescaler
  // ---------------------------------------------------------------------------
  assign tick = (pre_reg == PRE_LAST);

  always_ff @(posedge clk_50m) begin
    if (!rst) begin
      pre_reg <= '0;
    end else if (tick) begin
      pre_reg <= '0;
    end else begin
      pre_reg <= pre_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel synchroniser plus one delay flop for edge detection
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_sync
      logic s1_reg, s2_reg, prev_reg;

      always_ff @(posedge clk_50m) begin
        if (!rst) begin
          s1_reg   <= 1'b0;
          s2_reg   <= 1'b0;
          prev_reg <= 1'b0;
        end else begin
          s1_reg   <= echo[gi];
          s2_reg   <= s1_reg;
          prev_reg <= s2_reg;
        end
      end

      assign echo_sync[gi] = s2_reg;
      assign echo_prev[gi] = prev_reg;
    end
  endgenerate

  // Every channel is synchronised all the time. Only the one being serviced
  // feeds the edge detector. Because its delay flop is always live, an echo
  // that is already high when the rise wait begins produces no rising edge.
  assign sel_now   = echo_sync[ch_sel_reg];
  assign sel_prev  = echo_prev[ch_sel_reg];
  assign echo_rise = sel_now & ~sel_prev;
  assign echo_fall = ~sel_now & sel_prev;

  // ---------------------------------------------------------------------------
  // Sequencer state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_50m) begin
    if (!rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      slot_reg   <= '0;
      ch_sel_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      slot_reg   <= slot_next;
      ch_sel_reg <= ch_sel_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    slot_next   = slot_reg;
    ch_sel_next = ch_sel_reg;
    res_load    = 1'b0;
    res_to      = 1'b0;

    // The slot timer runs from trigger start until the slot closes.
    if (tick && (state_reg != IDLE)) begin
      slot_next = slot_reg + 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (en) begin
          state_next = TRIG;
          cnt_next   = '0;
          slot_next  = '0;
        end
      end

      // The first tick arms the trigger (cnt 0 -> 1). The pulse then spans
      // exactly TRIG_US tick periods, so its width does not depend on the
      // prescaler phase at which the slot started.
      TRIG: begin
        if (tick) begin
          if (cnt_reg == TRIG_END) begin
            state_next = WAIT_RISE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      WAIT_RISE: begin
        if (echo_rise) begin
          state_next = MEASURE;
          cnt_next   = '0;
        end else if (tick) begin
          if (cnt_reg == TO_LAST) begin
            res_load   = 1'b1;
            res_to     = 1'b1;
            state_next = GAP;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      // A falling edge is checked first. If it arrives on the same cycle as
      // the final timeout tick, it still yields a valid measurement.
      MEASURE: begin
        if (echo_fall) begin
          res_load   = 1'b1;
          state_next = GAP;
        end else if (tick && sel_now) begin
          if (cnt_reg == TO_LAST) begin
            res_load   = 1'b1;
            res_to     = 1'b1;
            state_next = GAP;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      GAP: begin
        if (tick && (slot_reg >= SLOT_LAST)) begin
          state_next  = IDLE;
          ch_sel_next = (ch_sel_reg == LAST_CH) ? '0 : ch_sel_reg + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign res_val = res_to ? {DIS_W{1'b1}} : cnt_reg[DIS_W-1:0];

  // ---------------------------------------------------------------------------
  // Per-channel result registers and trigger outputs
  // ---------------------------------------------------------------------------
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_chan
      logic             hit;
      logic [DIS_W-1:0] dis_reg;
      logic             to_reg;
      logic             dv_reg;
      logic             trig_reg;

      assign hit = (ch_sel_reg == CH_W'(gi));

      // The trigger is registered from next-state values. Reset therefore
      // drops it on the same edge, and the pin never glitches.
      always_ff @(posedge clk_50m) begin
        if (!rst) begin
          dis_reg  <= '0;
          to_reg   <= 1'b0;
          dv_reg   <= 1'b0;
          trig_reg <= 1'b0;
        end else begin
          dv_reg   <= res_load && hit;
          trig_reg <= hit && (state_next == TRIG) && (cnt_next != '0);
          if (res_load && hit) begin
            dis_reg <= res_val;
            to_reg  <= res_to;
          end
        end
      end

      assign dis[gi*DIS_W +: DIS_W] = dis_reg;
      assign timeout[gi]            = to_reg;
      assign dis_valid[gi]          = dv_reg;
      assign trig[gi]               = trig_reg;
    end
  endgenerate

  assign ch_sel = ch_sel_reg;
  assign busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_multi_sonic_ranger.sv
// -----------------------------------------------------------------------------
// tb_multi_sonic_ranger
//
// A driver walks the ranger through a list of slot scenarios: a normal echo,
// no echo, an over-long echo, and an echo already high before the rise wait,
// plus random ones. For each slot it pushes the expected result into a queue.
// A monitor pops the queue whenever a dis_valid strobe appears and compares.
// It also watches that unserviced channels hold their results and that trig
// stays one-hot on the selected channel.
// -----------------------------------------------------------------------------
module tb_multi_sonic_ranger;
  localparam int CLK_HZ     = 4_000_000;
  localparam int N_CH       = 2;
  localparam int DIS_W      = 16;
  localparam int TRIG_US    = 10;
  localparam int TIMEOUT_US = 200;
  localparam int PERIOD_US  = 500;
  localparam int DIV        = CLK_HZ / 1_000_000;
  localparam int ALL1       = (1 << DIS_W) - 1;

  localparam int K_NORMAL  = 0;
  localparam int K_NEVER   = 1;
  localparam int K_LONG    = 2;
  localparam int K_PREHIGH = 3;

  logic                  clk_50m = 1'b0;
  logic                  rst     = 1'b0;
  logic                  en      = 1'b0;
  logic [N_CH-1:0]       echo    = '0;
  logic [N_CH-1:0]       trig;
  logic [N_CH*DIS_W-1:0] dis;
  logic [N_CH-1:0]       dis_valid;
  logic [N_CH-1:0]       timeout;
  logic [0:0]            ch_sel;
  logic                  busy;

  always #5 clk_50m = ~clk_50m;

  multi_sonic_ranger #(
    .CLK_HZ    (CLK_HZ),
    .N_CH      (N_CH),
    .DIS_W     (DIS_W),
    .TRIG_US   (TRIG_US),
    .TIMEOUT_US(TIMEOUT_US),
    .PERIOD_US (PERIOD_US)
  ) dut (
    .clk_50m  (clk_50m),
    .rst      (rst),
    .en       (en),
    .echo     (echo),
    .trig     (trig),
    .dis      (dis),
    .dis_valid(dis_valid),
    .timeout  (timeout),
    .ch_sel   (ch_sel),
    .busy     (busy)
  );

  typedef struct packed {
    int ch;
    bit to;
    int dis;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   model_dis[N_CH];
  bit   model_to[N_CH];
  int   n_checks      = 0;
  int   n_pass        = 0;
  int   hold_err      = 0;
  int   trig_err      = 0;
  int   cyc           = 0;
  int   last_fall_cyc = 0;
  int   prev_rise_cyc = 0;

  always @(posedge clk_50m) cyc <= cyc + 1;

  task automatic check(input string name, input bit ok, input longint act, input longint req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic bail(input string name);
    check(name, 1'b0, 0, 1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  endtask

  function automatic int dis_of(input int c);
    return int'(dis[c*DIS_W +: DIS_W]);
  endfunction

  function automatic logic [N_CH-1:0] onehot(input int c);
    logic [N_CH-1:0] v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: compare every strobe against the scoreboard, watch hold/one-hot
  // ---------------------------------------------------------------------------
  always @(negedge clk_50m) begin
    if (!rst) begin
      for (int c = 0; c < N_CH; c++) begin
        model_dis[c] = 0;
        model_to[c]  = 1'b0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (dis_valid[c]) begin
          if (exp_q.size() == 0) begin
            check("unexpected_strobe", 1'b0, c, -1);
          end else begin
            mon_e = exp_q.pop_front();
            check("strobe_channel", c == mon_e.ch, c, mon_e.ch);
            check("timeout_flag", timeout[c] == mon_e.to, timeout[c], mon_e.to);
            if (mon_e.to) begin
              check("dis_on_timeout", dis_of(c) == ALL1, dis_of(c), ALL1);
            end else begin
              check("dis_value", (dis_of(c) >= mon_e.dis - 1) && (dis_of(c) <= mon_e.dis + 1),
                    dis_of(c), mon_e.dis);
              check("result_latency", (cyc - last_fall_cyc) <= 4, cyc - last_fall_cyc, 4);
            end
          end
          model_dis[c] = dis_of(c);
          model_to[c]  = timeout[c];
        end else if ((dis_of(c) != model_dis[c]) || (timeout[c] != model_to[c])) begin
          hold_err++;
        end
      end
      if ((trig != '0) && (trig != onehot(int'(ch_sel)))) trig_err++;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  task automatic wait_trig_rise();
    int n;
    n = 0;
    while ((trig == '0) && (n < 3 * PERIOD_US * DIV)) begin
      @(negedge clk_50m);
      n++;
    end
    if (trig == '0) bail("trig_rise_wait");
  endtask

  // Waits for the trigger, checks channel/period, and measures the pulse.
  // On return the trigger has just fallen.
  task automatic slot_start(input int exp_ch, input bit chk_period, input bit pre_high);
    int w;
    int rise_cyc;
    wait_trig_rise();
    rise_cyc = cyc;
    check("trig_channel", trig == onehot(exp_ch), trig, onehot(exp_ch));
    check("ch_sel", int'(ch_sel) == exp_ch, ch_sel, exp_ch);
    check("busy_in_slot", busy == 1'b1, busy, 1);
    if (chk_period) check("slot_period_clks", (rise_cyc - prev_rise_cyc) == PERIOD_US * DIV,
                          rise_cyc - prev_rise_cyc, PERIOD_US * DIV);
    prev_rise_cyc = rise_cyc;
    if (pre_high) echo[exp_ch] = 1'b1;
    w = 0;
    while ((trig != '0) && (w < 4 * TRIG_US * DIV)) begin
      w++;
      @(negedge clk_50m);
    end
    check("trig_width_clks", w == TRIG_US * DIV, w, TRIG_US * DIV);
  endtask

  task automatic run_slot(input int kind, input int delay, input int width,
                          input int exp_ch, input bit chk_period);
    exp_t e;
    int   other;
    int   hi0, hi1;
    bit   lvl;
    other = (exp_ch + 1) % N_CH;
    slot_start(exp_ch, chk_period, kind == K_PREHIGH);

    e.ch  = exp_ch;
    e.to  = (kind != K_NORMAL);
    e.dis = (kind == K_NORMAL) ? width : ALL1;
    exp_q.push_back(e);

    hi0 = 0;
    hi1 = 0;
    if ((kind == K_NORMAL) || (kind == K_LONG)) begin
      hi0 = delay;
      hi1 = delay + width;
    end else if (kind == K_PREHIGH) begin
      hi1 = 100;
    end

    for (int t = 0; t < 400; t++) begin
      lvl = (t >= hi0) && (t < hi1);
      if (echo[exp_ch] && !lvl) last_fall_cyc = cyc;
      echo[exp_ch] = lvl;
      echo[other]  = 1'($urandom_range(0, 1));
      repeat (DIV) @(negedge clk_50m);
    end
    echo = '0;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int kind;
    int n;
    int trig_hi;

    rst  = 1'b0;
    en   = 1'b0;
    echo = '0;
    repeat (5) @(negedge clk_50m);
    check("reset_trig", trig == '0, trig, 0);
    check("reset_dis", dis == '0, dis, 0);
    check("reset_dis_valid", dis_valid == '0, dis_valid, 0);
    check("reset_timeout", timeout == '0, timeout, 0);
    check("reset_busy", busy == 1'b0, busy, 0);
    check("reset_ch_sel", ch_sel == 1'b0, ch_sel, 0);

    rst = 1'b1;
    repeat (20) @(negedge clk_50m);
    check("idle_without_en", busy == 1'b0, busy, 0);

    en = 1'b1;
    run_slot(K_NORMAL,  20, 150, 0, 1'b0);
    run_slot(K_NEVER,    0,   0, 1, 1'b1);
    run_slot(K_LONG,    20, 300, 0, 1'b1);
    run_slot(K_NORMAL,  30,  50, 1, 1'b1);
    run_slot(K_PREHIGH,  0,   0, 0, 1'b1);
    for (int s = 0; s < 8; s++) begin
      n = $urandom_range(0, 9);
      kind = (n < 6) ? K_NORMAL : (n < 8) ? K_NEVER : K_LONG;
      run_slot(kind, $urandom_range(1, 100),
               (kind == K_LONG) ? 300 : $urandom_range(3, 180), (s + 1) % N_CH, 1'b1);
    end

    // Reset in the middle of a measurement on channel 1.
    slot_start(1, 1'b1, 1'b0);
    repeat (20 * DIV) @(negedge clk_50m);
    echo[1] = 1'b1;
    repeat (50 * DIV) @(negedge clk_50m);
    rst = 1'b0;
    @(negedge clk_50m);
    check("mid_reset_trig", trig == '0, trig, 0);
    check("mid_reset_dis", dis == '0, dis, 0);
    check("mid_reset_dis_valid", dis_valid == '0, dis_valid, 0);
    check("mid_reset_timeout", timeout == '0, timeout, 0);
    check("mid_reset_busy", busy == 1'b0, busy, 0);
    check("mid_reset_ch_sel", ch_sel == 1'b0, ch_sel, 0);
    echo = '0;
    repeat (5) @(negedge clk_50m);
    rst = 1'b1;

    // Ranging restarts at channel 0. Drop en while it waits for the echo.
    slot_start(0, 1'b0, 1'b0);
    en = 1'b0;
    begin
      exp_t e;
      e.ch  = 0;
      e.to  = 1'b1;
      e.dis = ALL1;
      exp_q.push_back(e);
    end
    n = 0;
    while (busy && (n < 3 * PERIOD_US * DIV)) begin
      @(negedge clk_50m);
      n++;
    end
    check("busy_after_en_drop", busy == 1'b0, busy, 0);
    check("ch_sel_after_en_drop", ch_sel == 1'b1, ch_sel, 1);
    check("timeout0_after_en_drop", timeout[0] == 1'b1, timeout[0], 1);
    trig_hi = 0;
    repeat (2 * PERIOD_US * DIV) begin
      @(negedge clk_50m);
      if (trig != '0) trig_hi++;
    end
    check("no_trig_after_en_drop", trig_hi == 0, trig_hi, 0);
    check("idle_after_en_drop", busy == 1'b0, busy, 0);

    check("scoreboard_drained", exp_q.size() == 0, exp_q.size(), 0);
    check("trig_onehot_on_ch_sel", trig_err == 0, trig_err, 0);
    check("unserviced_hold", hold_err == 0, hold_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
